commit_unit: RTL and testbench
==============================

# commit_unit

Retire-stage controller that consumes the two oldest ROB entries each cycle and decides how many retire. It drives the ROB's commit_req pop signals, writes the architectural register file, and hands committed stores to the store buffer through a valid/ready handshake. It also raises a one-cycle pipeline flush with a redirect PC when a retiring entry carries an exception or a branch misprediction.

## Interface
Parameters:
- AREG_WIDTH, 5, architectural register index width
- DATA_WIDTH, 32, data/PC width
- EXC_VECTOR, 32'h1C00_0000, redirect PC for exceptions

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- rob_valid_i  input  2  entry k complete and present (ROB c_valid)
- rob_areg_i  input  2×AREG_WIDTH  destination architectural register
- rob_w_reg_i  input  2  entry writes a register
- rob_w_mem_i  input  2  entry is a store
- rob_data_i  input  2×DATA_WIDTH  result data
- rob_exc_i  input  2  entry raised an exception (ctrl)
- rob_mispred_i  input  2  entry is a mispredicted branch (ctrl)
- rob_pc_i  input  2×DATA_WIDTH  entry PC
- rob_target_i  input  2×DATA_WIDTH  correct branch target
- commit_req_o  output  2  pop request to ROB; always thermometer (01, 11 or 00)
- arf_we_o  output  2  ARF write enable
- arf_waddr_o  output  2×AREG_WIDTH  ARF write address
- arf_wdata_o  output  2×DATA_WIDTH  ARF write data
- sb_commit_valid_o  output  1  store at slot 0/1 requests commit
- sb_commit_ready_i  input  1  store buffer accepts
- flush_o  output  1  pipeline flush pulse
- redirect_pc_o  output  DATA_WIDTH  fetch redirect PC, valid with flush_o
- epc_o  output  DATA_WIDTH  PC of excepting/mispredicted entry, valid with flush_o

## Operation
- FSM: RUN, FLUSH. Reset → RUN.
- RUN, slot 0 retires (r0) iff rob_valid_i[0] and (not store, or store with exception, or sb_commit_valid_o & sb_commit_ready_i).
- Slot 1 retires (r1) iff r0, rob_valid_i[1], slot 0 has neither exc nor mispred, not both slots stores, and slot 1 store condition as for slot 0.
- commit_req_o = {r1, r0}; FLUSH state forces 00.
- sb_commit_valid_o: asserted for the oldest non-excepting store eligible to retire this cycle (slot 0, or slot 1 under the r1 preconditions excluding its own store term). It does not depend on sb_commit_ready_i.
- arf_we_o[k] = rk & rob_w_reg_i[k] & !rob_exc_i[k] & (rob_areg_i[k] != 0). The address and data pass through from the inputs.
- A retiring entry with exc or mispred is the last retired this cycle. Next edge: state → FLUSH, flush_o=1, epc_o=its PC. redirect_pc_o=EXC_VECTOR if exc (exc wins over mispred), else rob_target_i.
- FLUSH lasts exactly one cycle, then → RUN.

## Timing
- commit_req_o, arf_*, sb_commit_valid_o: combinational, same cycle as ROB outputs.
- flush_o, redirect_pc_o, epc_o: registered, one cycle after the retiring cycle; 1-cycle pulse.
- Reset values: flush_o=0, redirect_pc_o=0, epc_o=0, state RUN. Combinational outputs are 0 while rob_valid_i=0.
- A store stalled on ready holds commit_req_o=00 and sb_commit_valid_o=1 until accepted.
- A reset asserted in FLUSH returns to RUN with flush_o=0 on the next edge.

## Configuration
- COMMIT_PERF_CNT_EN defined: adds output perf_commit_cnt_o (64-bit) counting retired entries (+0/+1/+2 per cycle). It resets to 0 and wraps modulo 2^64.
- COMMIT_PERF_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Both valid ALU ops, areg 3/4, data 0x11/0x22 → commit_req_o=11, arf_we_o=11 with those values; flush_o stays 0.
- Slot 0 areg=0, w_reg=1 → commit_req_o[0]=1, arf_we_o[0]=0.
- Slot 0 store, ready=0 for 3 cycles then 1 → commit_req_o=00 for 3 cycles, then 01 (or 11 if slot 1 is non-store) in the accept cycle.
- Slot 0 mispred, target 0x1C00_0100, slot 1 valid → commit_req_o=01, next cycle flush_o=1, redirect_pc_o=0x1C00_0100, commit_req_o=00 during FLUSH.
- Slot 1 exc and mispred together, pc 0x1C00_0040 → commit_req_o=11, arf_we_o[1]=0, next cycle redirect_pc_o=EXC_VECTOR, epc_o=0x1C00_0040.
- With COMMIT_PERF_CNT_EN: 10 cycles of dual retire → perf_commit_cnt_o=20; rst_n=0 one cycle → 0.

Source files
------------

// File: rtl/commit_unit_if.sv
// Retire-stage bus between the ROB, ARF, store buffer and the commit unit.
// The master modport is the commit unit's view; the slave modport is the environment's view.
interface commit_unit_if #(
    parameter int AREG_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              rob_valid_i;
    logic [2*AREG_WIDTH-1:0] rob_areg_i;
    logic [1:0]              rob_w_reg_i;
    logic [1:0]              rob_w_mem_i;
    logic [2*DATA_WIDTH-1:0] rob_data_i;
    logic [1:0]              rob_exc_i;
    logic [1:0]              rob_mispred_i;
    logic [2*DATA_WIDTH-1:0] rob_pc_i;
    logic [2*DATA_WIDTH-1:0] rob_target_i;
    logic [1:0]              commit_req_o;
    logic [1:0]              arf_we_o;
    logic [2*AREG_WIDTH-1:0] arf_waddr_o;
    logic [2*DATA_WIDTH-1:0] arf_wdata_o;
    logic                    sb_commit_valid_o;
    logic                    sb_commit_ready_i;
    logic                    flush_o;
    logic [DATA_WIDTH-1:0]   redirect_pc_o;
    logic [DATA_WIDTH-1:0]   epc_o;

    modport master (
        input  rob_valid_i, rob_areg_i, rob_w_reg_i, rob_w_mem_i, rob_data_i,
               rob_exc_i, rob_mispred_i, rob_pc_i, rob_target_i, sb_commit_ready_i,
        output commit_req_o, arf_we_o, arf_waddr_o, arf_wdata_o, sb_commit_valid_o,
               flush_o, redirect_pc_o, epc_o
    );

    modport slave (
        output rob_valid_i, rob_areg_i, rob_w_reg_i, rob_w_mem_i, rob_data_i,
               rob_exc_i, rob_mispred_i, rob_pc_i, rob_target_i, sb_commit_ready_i,
        input  commit_req_o, arf_we_o, arf_waddr_o, arf_wdata_o, sb_commit_valid_o,
               flush_o, redirect_pc_o, epc_o
    );
endinterface

// File: rtl/commit_unit.sv
// Dual-slot retire controller: pops the ROB, writes the ARF, hands stores to the store buffer
// and raises a one-cycle flush. Define COMMIT_PERF_CNT_EN to add a 64-bit retired-entry counter.
module commit_unit #(
    parameter int                    AREG_WIDTH = 5,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] EXC_VECTOR = 32'h1C00_0000
) (
    input logic           clk,
    input logic           rst_n,
    commit_unit_if.master bus
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [63:0]   perf_commit_cnt_o
`endif
);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]            state;
    logic                  run;
    logic                  hs;
    logic                  st0_ok;
    logic                  st1_ok;
    logic                  r0;
    logic                  r1;
    logic                  flush_take;
    logic                  flush_slot;
    logic [DATA_WIDTH-1:0] redirect_q;
    logic [DATA_WIDTH-1:0] epc_q;

    assign run = (state == ST_RUN);
    assign hs  = bus.sb_commit_valid_o & bus.sb_commit_ready_i;

    // Store eligibility excludes each slot's own ready term, so valid never waits on ready.
    assign st0_ok = run & bus.rob_valid_i[0] & bus.rob_w_mem_i[0] & ~bus.rob_exc_i[0];
    assign st1_ok = run & bus.rob_valid_i[0] & ~bus.rob_w_mem_i[0]
                  & ~bus.rob_exc_i[0] & ~bus.rob_mispred_i[0]
                  & bus.rob_valid_i[1] & bus.rob_w_mem_i[1] & ~bus.rob_exc_i[1];
    assign bus.sb_commit_valid_o = st0_ok | st1_ok;

    assign r0 = run & bus.rob_valid_i[0]
              & (~bus.rob_w_mem_i[0] | bus.rob_exc_i[0] | hs);
    assign r1 = r0 & bus.rob_valid_i[1]
              & ~bus.rob_exc_i[0] & ~bus.rob_mispred_i[0]
              & ~(bus.rob_w_mem_i[0] & bus.rob_w_mem_i[1])
              & (~bus.rob_w_mem_i[1] | bus.rob_exc_i[1] | hs);

    assign bus.commit_req_o = {r1, r0};

    always_comb begin
        bus.arf_we_o    = '0;
        bus.arf_waddr_o = '0;
        bus.arf_wdata_o = '0;
        for (int k = 0; k < 2; k++) begin
            bus.arf_we_o[k] = bus.commit_req_o[k] & bus.rob_w_reg_i[k] & ~bus.rob_exc_i[k]
                            & (bus.rob_areg_i[k*AREG_WIDTH +: AREG_WIDTH] != '0);
            if (bus.rob_valid_i[k]) begin
                bus.arf_waddr_o[k*AREG_WIDTH +: AREG_WIDTH] =
                    bus.rob_areg_i[k*AREG_WIDTH +: AREG_WIDTH];
                bus.arf_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] =
                    bus.rob_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Slot 1 can only retire when slot 0 is clean, so slot 0 has priority as flush source.
    always_comb begin
        flush_take = 1'b0;
        flush_slot = 1'b0;
        if (r0 & (bus.rob_exc_i[0] | bus.rob_mispred_i[0])) begin
            flush_take = 1'b1;
        end else if (r1 & (bus.rob_exc_i[1] | bus.rob_mispred_i[1])) begin
            flush_take = 1'b1;
            flush_slot = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            redirect_q <= '0;
            epc_q      <= '0;
        end else if (state == ST_FLUSH) begin
            state <= ST_RUN;
        end else if (flush_take) begin
            state <= ST_FLUSH;
            epc_q <= bus.rob_pc_i[flush_slot*DATA_WIDTH +: DATA_WIDTH];
            if (bus.rob_exc_i[flush_slot])
                redirect_q <= EXC_VECTOR;
            else
                redirect_q <= bus.rob_target_i[flush_slot*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign bus.flush_o       = (state == ST_FLUSH);
    assign bus.redirect_pc_o = redirect_q;
    assign bus.epc_o         = epc_q;

`ifdef COMMIT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_commit_cnt_o <= '0;
        else
            perf_commit_cnt_o <= perf_commit_cnt_o + 64'(r0) + 64'(r1);
    end
`endif
endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: the driver queues hand-computed expectations per cycle,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_commit_unit;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    commit_unit_if #(.AREG_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef COMMIT_PERF_CNT_EN
    logic [63:0] perf;
    commit_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus), .perf_commit_cnt_o(perf));
`else
    commit_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    we;
        logic          sbv;
        logic          flush;
        logic [31:0]   redir;
        logic [31:0]   epc;
        logic [2*AW-1:0] areg;
        logic [2*DW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("commit_req", 64'(bus.commit_req_o), 64'(e.req));
            chk("arf_we", 64'(bus.arf_we_o), 64'(e.we));
            chk("sb_valid", 64'(bus.sb_commit_valid_o), 64'(e.sbv));
            chk("flush", 64'(bus.flush_o), 64'(e.flush));
            chk("redirect_pc", 64'(bus.redirect_pc_o), 64'(e.redir));
            chk("epc", 64'(bus.epc_o), 64'(e.epc));
            for (int k = 0; k < 2; k++) begin
                if (e.we[k]) begin
                    chk("arf_waddr", 64'(bus.arf_waddr_o[k*AW +: AW]), 64'(e.areg[k*AW +: AW]));
                    chk("arf_wdata", 64'(bus.arf_wdata_o[k*DW +: DW]), 64'(e.data[k*DW +: DW]));
                end
            end
        end
    end

    task automatic clear_in();
        bus.rob_valid_i       = '0;
        bus.rob_areg_i        = '0;
        bus.rob_w_reg_i       = '0;
        bus.rob_w_mem_i       = '0;
        bus.rob_data_i        = '0;
        bus.rob_exc_i         = '0;
        bus.rob_mispred_i     = '0;
        bus.rob_pc_i          = '0;
        bus.rob_target_i      = '0;
        bus.sb_commit_ready_i = 1'b0;
    endtask

    task automatic set_slot(input int k, input logic [AW-1:0] areg, input logic wreg,
                            input logic wmem, input logic [DW-1:0] data, input logic exc,
                            input logic mis, input logic [DW-1:0] pc, input logic [DW-1:0] tgt);
        bus.rob_valid_i[k]          = 1'b1;
        bus.rob_areg_i[k*AW +: AW]  = areg;
        bus.rob_w_reg_i[k]          = wreg;
        bus.rob_w_mem_i[k]          = wmem;
        bus.rob_data_i[k*DW +: DW]  = data;
        bus.rob_exc_i[k]            = exc;
        bus.rob_mispred_i[k]        = mis;
        bus.rob_pc_i[k*DW +: DW]    = pc;
        bus.rob_target_i[k*DW +: DW] = tgt;
    endtask

    task automatic step(input logic [1:0] req, input logic [1:0] we, input logic sbv,
                        input logic flush, input logic [31:0] redir, input logic [31:0] epc);
        exp_t e;
        e.req = req; e.we = we; e.sbv = sbv; e.flush = flush;
        e.redir = redir; e.epc = epc;
        e.areg = bus.rob_areg_i; e.data = bus.rob_data_i;
        sb_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic two_alu();
        set_slot(0, 5'd3, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 32'h1C00_1000, 32'h0);
        set_slot(1, 5'd4, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 32'h1C00_1004, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state, idle
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        // dual ALU retire
        clear_in(); two_alu();
        step(2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
        // slot 0 writes x0
        clear_in();
        set_slot(0, 5'd0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0, 32'h0, 32'h0);
        set_slot(1, 5'd5, 1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2'b11, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        // slot 0 store stalled 3 cycles, then accepted with slot 1 ALU
        clear_in();
        set_slot(0, 5'd0, 1'b0, 1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 32'h0);
        set_slot(1, 5'd6, 1'b1, 1'b0, 32'h66, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 32'h0);
        bus.sb_commit_ready_i = 1'b1;
        step(2'b11, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        // slot 0 mispredict stops slot 1
        clear_in();
        set_slot(0, 5'd7, 1'b1, 1'b0, 32'h77, 1'b0, 1'b1, 32'h1C00_0080, 32'h1C00_0100);
        set_slot(1, 5'd8, 1'b1, 1'b0, 32'h88, 1'b0, 1'b0, 32'h1C00_0084, 32'h0);
        step(2'b01, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
        // flush cycle blocks everything
        clear_in(); two_alu();
        step(2'b00, 2'b00, 1'b0, 1'b1, 32'h1C00_0100, 32'h1C00_0080);
        // slot 1 exc + mispred: exception wins
        clear_in();
        set_slot(0, 5'd1, 1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 32'h1C00_003C, 32'h0);
        set_slot(1, 5'd2, 1'b1, 1'b0, 32'hAA, 1'b1, 1'b1, 32'h1C00_0040, 32'h1C00_0200);
        step(2'b11, 2'b01, 1'b0, 1'b0, 32'h1C00_0100, 32'h1C00_0080);
        clear_in();
        step(2'b00, 2'b00, 1'b0, 1'b1, 32'h1C00_0000, 32'h1C00_0040);
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h1C00_0000, 32'h1C00_0040);
        // excepting store retires without the store buffer
        set_slot(0, 5'd0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h1C00_0300, 32'h0);
        step(2'b01, 2'b00, 1'b0, 1'b0, 32'h1C00_0000, 32'h1C00_0040);
        clear_in();
        step(2'b00, 2'b00, 1'b0, 1'b1, 32'h1C00_0000, 32'h1C00_0300);
        // slot 1 store: valid without ready, retires on ready
        set_slot(0, 5'd8, 1'b1, 1'b0, 32'hBB, 1'b0, 1'b0, 32'h0, 32'h0);
        set_slot(1, 5'd0, 1'b0, 1'b1, 32'hCC, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2'b01, 2'b01, 1'b1, 1'b0, 32'h1C00_0000, 32'h1C00_0300);
        bus.sb_commit_ready_i = 1'b1;
        step(2'b11, 2'b01, 1'b1, 1'b0, 32'h1C00_0000, 32'h1C00_0300);
        // two stores: only the oldest goes
        clear_in();
        set_slot(0, 5'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_slot(1, 5'd0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.sb_commit_ready_i = 1'b1;
        step(2'b01, 2'b00, 1'b1, 1'b0, 32'h1C00_0000, 32'h1C00_0300);
        // slot 1 alone cannot retire
        clear_in();
        set_slot(1, 5'd9, 1'b1, 1'b0, 32'hDD, 1'b0, 1'b0, 32'h0, 32'h0);
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h1C00_0000, 32'h1C00_0300);
        // exception then reset during the flush cycle
        clear_in();
        set_slot(0, 5'd9, 1'b1, 1'b0, 32'hEE, 1'b1, 1'b0, 32'h1C00_0400, 32'h0);
        step(2'b01, 2'b00, 1'b0, 1'b0, 32'h1C00_0000, 32'h1C00_0300);
        clear_in();
        rst_n = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b1, 32'h1C00_0000, 32'h1C00_0400);
        rst_n = 1'b1;
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef COMMIT_PERF_CNT_EN
        rst_n = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        two_alu();
        for (int i = 0; i < 10; i++) step(2'b11, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("perf_cnt_20", perf, 64'd20);
        clear_in();
        rst_n = 1'b0;
        step(2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        chk("perf_cnt_reset", perf, 64'd0);
`endif

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule
